ip_tx_arbiter: RTL and testbench

IP_TX_ARBITER -- requirements
Module: ip_tx_arbiter

---
 rtl/ip_tx_arbiter_if.sv | 36 +++
 rtl/ip_tx_arbiter.sv | 77 +++++++
 tb/tb_ip_tx_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ip_tx_arbiter_if.sv
// ip_tx_arbiter_if: requester streams, merged output stream and IP sideband.
// The master modport is the arbiter side, and the slave modport is the environment side.
interface ip_tx_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int AXIS_BYTES = 4
);
    logic [NUM_PORTS-1:0]              axis_i_tvalid;
    logic [NUM_PORTS-1:0]              axis_i_tready;
    logic [NUM_PORTS-1:0]              axis_i_tlast;
    logic [NUM_PORTS*AXIS_BYTES-1:0]   axis_i_tkeep;
    logic [NUM_PORTS*AXIS_BYTES*8-1:0] axis_i_tdata;
    logic [NUM_PORTS*16-1:0]           axis_i_length;
    logic [NUM_PORTS*8-1:0]            axis_i_protocol;
    logic [NUM_PORTS*32-1:0]           axis_i_dst_ip;
    logic                              axis_o_tvalid;
    logic                              axis_o_tready;
    logic                              axis_o_tlast;
    logic [AXIS_BYTES-1:0]             axis_o_tkeep;
    logic [AXIS_BYTES*8-1:0]           axis_o_tdata;
    logic [15:0]                       axis_o_length;
    logic [7:0]                        axis_o_protocol;
    logic [31:0]                       axis_o_dst_ip;
    logic [$clog2(NUM_PORTS)-1:0]      axis_o_sel;
    modport master (
        input  axis_i_tvalid, axis_i_tlast, axis_i_tkeep, axis_i_tdata,
               axis_i_length, axis_i_protocol, axis_i_dst_ip, axis_o_tready,
        output axis_i_tready, axis_o_tvalid, axis_o_tlast, axis_o_tkeep, axis_o_tdata,
               axis_o_length, axis_o_protocol, axis_o_dst_ip, axis_o_sel
    );
    modport slave (
        output axis_i_tvalid, axis_i_tlast, axis_i_tkeep, axis_i_tdata,
               axis_i_length, axis_i_protocol, axis_i_dst_ip, axis_o_tready,
        input  axis_i_tready, axis_o_tvalid, axis_o_tlast, axis_o_tkeep, axis_o_tdata,
               axis_o_length, axis_o_protocol, axis_o_dst_ip, axis_o_sel
    );
endinterface

// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter: packet-level arbiter that merges NUM_PORTS AXI-Stream requesters and registers the IP sideband of the granted port.
// The default build uses round-robin arbitration. Define IP_TX_ARB_STRICT_PRIORITY_EN to grant the lowest-numbered valid port instead.
module ip_tx_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int AXIS_BYTES = 4
) (
    input logic             clk,
    input logic             sresetn,
    ip_tx_arbiter_if.master bus
);
    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int DW    = AXIS_BYTES * 8;
`ifdef IP_TX_ARB_STRICT_PRIORITY_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif
    typedef enum logic {IDLE, PASS} state_t;
    state_t               r_state;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     r_rr_ptr;
    logic [15:0]          r_length;
    logic [7:0]           r_protocol;
    logic [31:0]          r_dst_ip;
    logic [NUM_PORTS-1:0] w_rot;
    logic [SEL_W-1:0]     w_off;
    logic [SEL_W:0]       w_sum;
    logic [SEL_W-1:0]     w_win;
    logic [SEL_W-1:0]     w_next_ptr;
    logic                 w_done;

    // Rotate the requests so that rr_ptr becomes bit 0. The lowest set bit then gives the offset of the winner.
    assign w_rot = NUM_PORTS'({bus.axis_i_tvalid, bus.axis_i_tvalid} >> r_rr_ptr);
    always_comb begin
        w_off = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (w_rot[i]) w_off = SEL_W'(i);
    end
    assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_win      = (w_sum >= (SEL_W+1)'(NUM_PORTS)) ? SEL_W'(w_sum - (SEL_W+1)'(NUM_PORTS)) : SEL_W'(w_sum);
    assign w_next_ptr = (r_sel == SEL_W'(NUM_PORTS - 1)) ? '0 : r_sel + SEL_W'(1);
    assign w_done     = bus.axis_o_tvalid && bus.axis_o_tready && bus.axis_o_tlast;

    always_comb begin
        bus.axis_i_tready        = '0;
        bus.axis_i_tready[r_sel] = (r_state == PASS) && bus.axis_o_tready;
    end
    assign bus.axis_o_tvalid   = (r_state == PASS) && bus.axis_i_tvalid[r_sel];
    assign bus.axis_o_tlast    = bus.axis_i_tlast[r_sel];
    assign bus.axis_o_tkeep    = bus.axis_i_tkeep[r_sel*AXIS_BYTES +: AXIS_BYTES];
    assign bus.axis_o_tdata    = bus.axis_i_tdata[r_sel*DW +: DW];
    assign bus.axis_o_sel      = r_sel;
    assign bus.axis_o_length   = r_length;
    assign bus.axis_o_protocol = r_protocol;
    assign bus.axis_o_dst_ip   = r_dst_ip;

    always_ff @(posedge clk or negedge sresetn)
        if (!sresetn) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_rr_ptr   <= '0;
            r_length   <= '0;
            r_protocol <= '0;
            r_dst_ip   <= '0;
        end else if (r_state == IDLE) begin
            if (|bus.axis_i_tvalid) begin
                r_state    <= PASS;
                r_sel      <= w_win;
                r_length   <= bus.axis_i_length[w_win*16 +: 16];
                r_protocol <= bus.axis_i_protocol[w_win*8 +: 8];
                r_dst_ip   <= bus.axis_i_dst_ip[w_win*32 +: 32];
            end
        end else if (w_done) begin
            r_state  <= IDLE;
            r_rr_ptr <= STRICT ? r_rr_ptr : w_next_ptr;
        end
endmodule

// File: tb/tb_ip_tx_arbiter.sv
// tb_ip_tx_arbiter: directed bench for ip_tx_arbiter with two ports. The expected grants follow IP_TX_ARB_STRICT_PRIORITY_EN.
module tb_ip_tx_arbiter;
    logic clk = 1'b0;
    logic sresetn;
    int   checks = 0;
    int   errors = 0;
    int   exp_order [4];
    int   g;

    always #5 clk = ~clk;

    ip_tx_arbiter_if #(.NUM_PORTS(2), .AXIS_BYTES(4)) bus ();
    ip_tx_arbiter #(.NUM_PORTS(2), .AXIS_BYTES(4)) dut (.clk(clk), .sresetn(sresetn), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input int p, input logic v, input logic l, input logic [31:0] d);
        bus.axis_i_tvalid[p]          = v;
        bus.axis_i_tlast[p]           = l;
        bus.axis_i_tdata[p*32 +: 32]  = d;
    endtask

    task automatic side(input int p, input logic [15:0] len, input logic [7:0] pr, input logic [31:0] ip);
        bus.axis_i_length[p*16 +: 16]  = len;
        bus.axis_i_protocol[p*8 +: 8]  = pr;
        bus.axis_i_dst_ip[p*32 +: 32]  = ip;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef IP_TX_ARB_STRICT_PRIORITY_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        sresetn             = 1'b0;
        bus.axis_i_tvalid   = '0;
        bus.axis_i_tlast    = '0;
        bus.axis_i_tkeep    = '1;
        bus.axis_i_tdata    = '0;
        bus.axis_i_length   = '0;
        bus.axis_i_protocol = '0;
        bus.axis_i_dst_ip   = '0;
        bus.axis_o_tready   = 1'b1;
        nx();
        nx();
        chk("rst_sel", 32'(bus.axis_o_sel), 0);
        chk("rst_len", 32'(bus.axis_o_length), 0);
        chk("rst_proto", 32'(bus.axis_o_protocol), 0);
        chk("rst_dst", bus.axis_o_dst_ip, 0);
        chk("rst_tvalid", 32'(bus.axis_o_tvalid), 0);
        chk("rst_tready", 32'(bus.axis_i_tready), 0);

        // Three-beat packet on port 1
        sresetn = 1'b1;
        side(1, 16'd12, 8'd17, 32'h0A00_0001);
        drv(1, 1'b1, 1'b0, 32'h1111_0001);
        #1;
        chk("a_idle_tvalid", 32'(bus.axis_o_tvalid), 0);
        chk("a_idle_tready", 32'(bus.axis_i_tready), 0);
        nx();
        side(1, 16'd99, 8'd1, 32'hDEAD_BEEF);
        #1;
        chk("a_sel", 32'(bus.axis_o_sel), 1);
        chk("a_len", 32'(bus.axis_o_length), 12);
        chk("a_proto", 32'(bus.axis_o_protocol), 17);
        chk("a_dst", bus.axis_o_dst_ip, 32'h0A00_0001);
        chk("a_b1_tvalid", 32'(bus.axis_o_tvalid), 1);
        chk("a_b1_tdata", bus.axis_o_tdata, 32'h1111_0001);
        chk("a_b1_tready", 32'(bus.axis_i_tready), 2);
        nx();
        drv(1, 1'b1, 1'b0, 32'h1111_0002);
        #1;
        chk("a_b2_tdata", bus.axis_o_tdata, 32'h1111_0002);
        chk("a_b2_tlast", 32'(bus.axis_o_tlast), 0);
        chk("a_len_hold", 32'(bus.axis_o_length), 12);
        nx();
        drv(1, 1'b1, 1'b1, 32'h1111_0003);
        #1;
        chk("a_b3_tdata", bus.axis_o_tdata, 32'h1111_0003);
        chk("a_b3_tlast", 32'(bus.axis_o_tlast), 1);
        nx();
        drv(1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("a_end_tvalid", 32'(bus.axis_o_tvalid), 0);
        chk("a_end_tready", 32'(bus.axis_i_tready), 0);

        // Both ports stay valid and send single-beat packets
        side(0, 16'd4, 8'd6, 32'h0A00_0000);
        side(1, 16'd8, 8'd17, 32'h0A00_0002);
        drv(0, 1'b1, 1'b1, 32'hAAAA_0000);
        drv(1, 1'b1, 1'b1, 32'hBBBB_1111);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("b_idle_tvalid", 32'(bus.axis_o_tvalid), 0);
            nx();
            #1;
            g = exp_order[k];
            chk("b_sel", 32'(bus.axis_o_sel), 32'(g));
            chk("b_tvalid", 32'(bus.axis_o_tvalid), 1);
            chk("b_tdata", bus.axis_o_tdata, (g == 0) ? 32'hAAAA_0000 : 32'hBBBB_1111);
            chk("b_tready", 32'(bus.axis_i_tready), (g == 0) ? 32'd1 : 32'd2);
            chk("b_len", 32'(bus.axis_o_length), (g == 0) ? 32'd4 : 32'd8);
            nx();
        end

        // Port 0 stalls in the middle of its packet while port 1 keeps requesting
        drv(0, 1'b1, 1'b0, 32'hA0A0_0000);
        drv(1, 1'b1, 1'b1, 32'hBBBB_2222);
        nx();
        #1;
        chk("c_sel", 32'(bus.axis_o_sel), 0);
        chk("c_b1_tdata", bus.axis_o_tdata, 32'hA0A0_0000);
        nx();
        drv(0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("c_gap_tvalid", 32'(bus.axis_o_tvalid), 0);
            chk("c_gap_tready", 32'(bus.axis_i_tready), 1);
            chk("c_gap_sel", 32'(bus.axis_o_sel), 0);
            nx();
        end
        drv(0, 1'b1, 1'b1, 32'hA0A0_0001);
        #1;
        chk("c_b2_tvalid", 32'(bus.axis_o_tvalid), 1);
        chk("c_b2_tdata", bus.axis_o_tdata, 32'hA0A0_0001);
        chk("c_b2_tlast", 32'(bus.axis_o_tlast), 1);
        chk("c_b2_sel", 32'(bus.axis_o_sel), 0);
        nx();
        drv(0, 1'b0, 1'b0, 32'h0);
        drv(1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("c_end_tvalid", 32'(bus.axis_o_tvalid), 0);

        // The output stalls for 4 cycles in the middle of a packet
        side(0, 16'd40, 8'd6, 32'hC0A8_0001);
        drv(0, 1'b1, 1'b0, 32'hB0B0_0000);
        nx();
        #1;
        chk("d_sel", 32'(bus.axis_o_sel), 0);
        chk("d_b1_tdata", bus.axis_o_tdata, 32'hB0B0_0000);
        nx();
        drv(0, 1'b1, 1'b0, 32'hB0B0_0001);
        side(0, 16'd77, 8'd9, 32'h0);
        bus.axis_o_tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("d_stall_tdata", bus.axis_o_tdata, 32'hB0B0_0001);
            chk("d_stall_tlast", 32'(bus.axis_o_tlast), 0);
            chk("d_stall_tvalid", 32'(bus.axis_o_tvalid), 1);
            chk("d_stall_len", 32'(bus.axis_o_length), 40);
            chk("d_stall_dst", bus.axis_o_dst_ip, 32'hC0A8_0001);
            chk("d_stall_tready", 32'(bus.axis_i_tready), 0);
            nx();
        end
        bus.axis_o_tready = 1'b1;
        #1;
        chk("d_b2_tdata", bus.axis_o_tdata, 32'hB0B0_0001);
        chk("d_b2_tready", 32'(bus.axis_i_tready), 1);
        nx();
        drv(0, 1'b1, 1'b1, 32'hB0B0_0002);
        #1;
        chk("d_b3_tdata", bus.axis_o_tdata, 32'hB0B0_0002);
        chk("d_b3_tlast", 32'(bus.axis_o_tlast), 1);
        nx();
        drv(0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("d_end_tvalid", 32'(bus.axis_o_tvalid), 0);

        // Reset is asserted on beat 2 of a 4-beat packet on port 1
        side(1, 16'd16, 8'd17, 32'h0A00_0003);
        drv(1, 1'b1, 1'b0, 32'hC0C0_0000);
        nx();
        #1;
        chk("e_sel", 32'(bus.axis_o_sel), 1);
        nx();
        drv(1, 1'b1, 1'b0, 32'hC0C0_0001);
        #1;
        chk("e_b2_tvalid", 32'(bus.axis_o_tvalid), 1);
        sresetn = 1'b0;
        #1;
        chk("e_rst_tvalid", 32'(bus.axis_o_tvalid), 0);
        chk("e_rst_tready", 32'(bus.axis_i_tready), 0);
        chk("e_rst_sel", 32'(bus.axis_o_sel), 0);
        chk("e_rst_len", 32'(bus.axis_o_length), 0);
        drv(0, 1'b1, 1'b0, 32'hD0D0_0000);
        nx();
        sresetn = 1'b1;
        nx();
        #1;
        chk("e_regrant_sel", 32'(bus.axis_o_sel), 0);
        chk("e_regrant_tvalid", 32'(bus.axis_o_tvalid), 1);
        chk("e_regrant_tready", 32'(bus.axis_i_tready), 1);
        chk("e_regrant_tdata", bus.axis_o_tdata, 32'hD0D0_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
